// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle multiply/divide sequencer for the E stage.
// Owns the architectural HI/LO registers. The result is computed when the
// operation starts, held in a pending buffer, and committed to HI/LO after
// the fixed latency of the operation has elapsed.
module mdu_seq #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  mode,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        pend_hi_q, pend_hi_d;
    logic [31:0]        pend_lo_q, pend_lo_d;
    logic               pend_ok_q, pend_ok_d;

    // 64-bit product; sign-extending to 64 bits makes the low 64 bits of an
    // unsigned multiply equal to the signed product.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = {{32{sgn & a[31]}}, a};
        eb = {{32{sgn & b[31]}}, b};
        return ea * eb;
    endfunction

    // Returns {remainder, quotient}. Works on magnitudes so the quotient
    // truncates toward zero and the remainder follows the dividend's sign.
    // 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
    // A zero divisor is replaced by 1 only to keep the datapath X-free; that
    // result is never committed.
    function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic        na;
        logic        nb;
        logic [31:0] ua;
        logic [31:0] ub;
        logic [31:0] q;
        logic [31:0] r;
        na = sgn & a[31];
        nb = sgn & b[31];
        ua = na ? -a : a;
        ub = nb ? -b : b;
        if (ub == 32'd0) ub = 32'd1;
        q = ua / ub;
        r = ua % ub;
        if (na ^ nb) q = -q;
        if (na)      r = -r;
        return {r, q};
    endfunction

    // Next-state logic for the sequencer and the HI/LO/pending registers
    always_comb begin
        logic [63:0] res;
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_ok_d = pend_ok_q;
        res       = mode[1] ? div64(src_a, src_b, ~mode[0]) : mul64(src_a, src_b, ~mode[0]);
        case (state_q)
            IDLE: begin
                if (start && !mode[2]) begin
                    pend_hi_d = res[63:32];
                    pend_lo_d = res[31:0];
                    pend_ok_d = !(mode[1] && src_b == 32'd0);
                    cnt_d     = mode[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                    state_d   = RUN;
                    busy_d    = 1'b1;
                end else if (!start && mode == 3'd4) begin
                    hi_d = src_a;
                end else if (!start && mode == 3'd5) begin
                    lo_d = src_a;
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    if (pend_ok_q) begin
                        hi_d   = pend_hi_q;
                        lo_d   = pend_lo_q;
                        done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset dominates and discards any pending result
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_ok_q <= pend_ok_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign stall = d_is_md & (busy_q | start);

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle sequencer for the E-stage multiply/divide unit; owns the architectural HI/LO registers.
- Accepts start/mode from the decoder, counts fixed latency, commits results to HI/LO.
- Raises the D-stage stall for any HI/LO-touching instruction while an operation is pending.
- Also handles mthi/mtlo writes.
- Sits beside the ALU in E; HI/LO feed the M-stage forward mux and the W write-data mux.

Parameters:
- MUL_CYCLES, 5, busy cycles for mult/multu (must be >=1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- start  input  1  E-stage start pulse, high only for mult/multu/div/divu.
- mode  input  3  operation: 0 mul signed, 1 mul unsigned, 2 div signed, 3 div unsigned, 4 move-to-HI, 5 move-to-LO, 7 none.
- src_a  input  32  E-stage rs value (dividend / multiplicand / mthi-mtlo data).
- src_b  input  32  E-stage rt value (divisor / multiplier).
- d_is_md  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  output  1  operation in progress.
- stall  output  1  D-stage stall request (combinational).
- done  output  1  one-cycle pulse in the cycle HI/LO take a new result.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- States: IDLE, RUN.
- Reset (reset_n low at a clk edge): state IDLE; counter, busy, done at 0; hi, lo at 0; pending result discarded. Reset dominates all other inputs, including mid-operation.
- IDLE, start=1, mode 0-3:
  - Capture the full result into internal pending_hi/pending_lo at that edge.
  - Load counter with MUL_CYCLES (mode 0/1) or DIV_CYCLES (mode 2/3); go to RUN.
  - busy is registered: high from the cycle after the start edge.
- RUN: counter decrements each edge. busy stays high for exactly N cycles (N = loaded count).
- At the edge ending the Nth busy cycle:
  - hi/lo get the pending values; state returns to IDLE.
  - done is high for the following single cycle, together with busy=0.
- Multiply: 64-bit product; signed (mode 0) or unsigned (mode 1) interpretation; hi = [63:32], lo = [31:0].
- Divide:
  - lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
  - Divisor 0: the operation still runs DIV_CYCLES with busy high, but hi/lo keep their previous values and done does not pulse.
- Move-to, IDLE only: mode 4 writes hi <= src_a and mode 5 writes lo <= src_a at the next edge; neither asserts busy.
- start, or mode 4/5, while in RUN: ignored. The stall makes this unreachable under legal sequencing.
- start with mode 4-7: ignored.
- stall = d_is_md & (busy | start). Combinational, no added latency; covers the start cycle before busy rises.
- Back-to-back ops: a start in the first cycle after completion (busy=0) is accepted normally.

Test Plan:
- mult, src_a=0xFFFFFFFD, src_b=5 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulses once.
- multu, 0xFFFFFFFF x 0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- div, src_a=0xFFFFFFF9 (-7), src_b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu, 7/2 -> lo=3, hi=1.
- Preload hi=0x11 and lo=0x22 via mode 4/5; then div x/0 -> busy 10 cycles, no done pulse, hi=0x11 and lo=0x22 unchanged.
- Stall, reset and ignore rules:
  - start (mult) with d_is_md=1 held -> stall=1 in the start cycle and all 5 busy cycles, stall=0 after.
  - mode 4 in busy cycle 2 -> hi unchanged.
  - reset_n low in busy cycle 3 -> busy=0, hi=lo=0 next cycle, no done pulse.
